retention_power_sequencer: RTL and testbench
============================================

Name: retention_power_sequencer

Overview:
- Power-domain controller that sits directly upstream of the domain's retention registers.
- Drives their save/restore strobes plus the domain's isolation, clock enable, domain reset and power-switch enable.
- Runs a fixed, ordered power-down sequence on sleep_req and the reverse power-up sequence on wake_req, handshaking with the power switch through pwr_ack.
- Lives in the always-on domain.

Parameters:
- SETTLE_CYC, 2: cycles spent in each timed settle state; legal range 1 to 255.
- ACK_TIMEOUT, 16: maximum cycles to wait for a pwr_ack transition; legal range 1 to 65535; used only with the optional feature.

Ports:
- clk  in  1  single clock; the block uses one clock, clk.
- rst  in  1  reset; reset is synchronous and active-high.
- sleep_req  in  1  request power-down; level, sampled in RUN only.
- wake_req  in  1  request power-up; level, sampled in SLEEP only.
- pwr_ack  in  1  power-switch status; 1 = domain powered, 0 = domain off.
- save  out  1  one-cycle strobe to the retention registers' save input.
- restore  out  1  one-cycle strobe to the retention registers' restore input.
- iso_en  out  1  1 = domain outputs clamped.
- clk_en  out  1  domain clock-gate enable.
- dom_rst_n  out  1  domain reset, active-low.
- pwr_en  out  1  power-switch enable.
- sleeping  out  1  1 only in SLEEP.
- busy  out  1  1 in every state except RUN and SLEEP.
- err  out  1  sticky pwr_ack timeout flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=RUN, settle counter=0, timeout counter=0, err=0.
  - Outputs: save=0, restore=0, iso_en=0, clk_en=1, dom_rst_n=1, pwr_en=1, sleeping=0, busy=0.
  - rst mid-sequence aborts the sequence and returns to RUN with these values.
- Moore machine: every output is decoded from the state register only. No combinational path from any input to any output.
- State outputs (only fields that change from the previous state are listed):
  - RUN: iso0 clk1 rst_n1 pwr1.
  - SAVE: save=1.
  - ISO_ON: save=0, iso=1.
  - CLK_OFF: clk=0.
  - RST_ON: rst_n=0.
  - PWR_OFF: pwr=0.
  - SLEEP: sleeping=1.
  - PWR_ON: pwr=1, sleeping=0.
  - RST_OFF: rst_n=1.
  - CLK_ON: clk=1.
  - RESTORE: restore=1.
  - ISO_OFF: restore=0, iso=0.
- Power-down transitions: RUN -(sleep_req)-> SAVE (1 cycle) -> ISO_ON (S) -> CLK_OFF (S) -> RST_ON (S) -> PWR_OFF -(pwr_ack==0)-> SLEEP.
- Power-up transitions: SLEEP -(wake_req)-> PWR_ON -(pwr_ack==1)-> RST_OFF (S) -> CLK_ON (S) -> RESTORE (1 cycle) -> ISO_OFF (S) -> RUN.
- Timed states last exactly S=SETTLE_CYC cycles. The counter loads on state entry and the state advances when it expires.
- Ack-wait states last at least 1 cycle; pwr_ack is sampled at each edge while in the state.
- Minimum latency:
  - Edge sampling sleep_req=1 in RUN to first cycle of SLEEP: 3S+2 cycles.
  - Edge sampling wake_req=1 in SLEEP to first cycle of RUN: 3S+2 cycles.
- save is asserted while clk_en=1. restore is asserted only after dom_rst_n=1 and clk_en=1, both with iso_en=1.
- Simultaneous and ignored events:
  - sleep_req and wake_req both high in RUN: sleep wins.
  - wake_req during power-down is ignored; the sequence completes to SLEEP, then leaves SLEEP the next edge if wake_req is still high.
  - sleep_req outside RUN is ignored.
  - sleep_req held high through power-up re-enters SAVE the cycle after RUN (RUN lasts 1 cycle).
- pwr_ack glitching in states other than PWR_OFF and PWR_ON is ignored.

Optional Feature:
- Macro: RET_SEQ_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to PWR_OFF and PWR_ON.
  - PWR_OFF not acked within ACK_TIMEOUT cycles: err<=1, abort to PWR_ON. The domain never lost state, so the normal wake path completes to RUN.
  - PWR_ON not acked within ACK_TIMEOUT cycles: err<=1, remain in PWR_ON waiting.
  - err clears only on rst.
- Undefined: ack waits are unbounded and err is tied to 0.

Test Plan:
- Reset: assert rst 2 cycles -> RUN, pwr_en=1, clk_en=1, dom_rst_n=1, iso_en=0, save=0, restore=0, busy=0, err=0.
- Power-down, S=2, pwr_ack falls in first PWR_OFF cycle, sleep_req pulse 1 cycle:
  - save high exactly 1 cycle.
  - iso_en rises before clk_en falls, clk_en falls before dom_rst_n falls, dom_rst_n falls before pwr_en falls.
  - sleeping=1 exactly 8 cycles after the sampling edge.
- Power-up from SLEEP, wake_req pulse, pwr_ack rises 3 cycles after pwr_en:
  - restore pulses 1 cycle with dom_rst_n=1, clk_en=1, iso_en=1.
  - RUN reached 10 cycles after the sampling edge.
  - Retention register reads back its pre-sleep value, e.g. 0xDEADBEEF.
- sleep_req and wake_req both high in RUN -> SAVE entered. wake_req held high throughout -> SLEEP lasts 1 cycle, then PWR_ON.
- With RET_SEQ_TIMEOUT_EN, ACK_TIMEOUT=8, pwr_ack stuck 1:
  - err=1 after 8 PWR_OFF cycles.
  - Block walks the wake path to RUN with restore pulsed once.
  - err remains 1 until rst.
- rst asserted in CLK_OFF -> next cycle RUN, clk_en=1, pwr_en=1, iso_en=0, busy=0.

Source files
------------

// File: rtl/retention_power_sequencer.sv
// retention_power_sequencer: retention save/restore power-domain sequencer; define RET_SEQ_TIMEOUT_EN for pwr_ack timeout with sticky err
module retention_power_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sleep_req,
  input  logic wake_req,
  input  logic pwr_ack,
  output logic save,
  output logic restore,
  output logic iso_en,
  output logic clk_en,
  output logic dom_rst_n,
  output logic pwr_en,
  output logic sleeping,
  output logic busy,
  output logic err
);
  typedef enum logic [3:0] {
    RUN, SAVE, ISO_ON, CLK_OFF, RST_ON, PWR_OFF, SLEEP,
    PWR_ON, RST_OFF, CLK_ON, RESTORE, ISO_OFF
  } state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic done, tmo;
  assign done = cnt == 8'd0;
  always_comb begin
    nxt = state;
    case (state)
      RUN:     nxt = sleep_req ? SAVE : RUN;
      SAVE:    nxt = ISO_ON;
      ISO_ON:  nxt = done ? CLK_OFF : ISO_ON;
      CLK_OFF: nxt = done ? RST_ON : CLK_OFF;
      RST_ON:  nxt = done ? PWR_OFF : RST_ON;
      PWR_OFF: nxt = !pwr_ack ? SLEEP : tmo ? PWR_ON : PWR_OFF;
      SLEEP:   nxt = wake_req ? PWR_ON : SLEEP;
      PWR_ON:  nxt = pwr_ack ? RST_OFF : PWR_ON;
      RST_OFF: nxt = done ? CLK_ON : RST_OFF;
      CLK_ON:  nxt = done ? RESTORE : CLK_ON;
      RESTORE: nxt = ISO_OFF;
      ISO_OFF: nxt = done ? RUN : ISO_OFF;
      default: nxt = RUN;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? 8'(SETTLE_CYC - 1) : done ? cnt : cnt - 8'd1;
    end
  assign save      = state == SAVE;
  assign restore   = state == RESTORE;
  assign iso_en    = !(state inside {RUN, SAVE, ISO_OFF});
  assign clk_en    = !(state inside {CLK_OFF, RST_ON, PWR_OFF, SLEEP, PWR_ON, RST_OFF});
  assign dom_rst_n = !(state inside {RST_ON, PWR_OFF, SLEEP, PWR_ON});
  assign pwr_en    = !(state inside {PWR_OFF, SLEEP});
  assign sleeping  = state == SLEEP;
  assign busy      = !(state inside {RUN, SLEEP});
`ifdef RET_SEQ_TIMEOUT_EN
  logic [15:0] tcnt;
  logic waiting, err_q;
  assign waiting = (state == PWR_OFF && pwr_ack) || (state == PWR_ON && !pwr_ack);
  assign tmo = waiting && tcnt == 16'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      tcnt <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= (nxt != state) ? '0 : tcnt + 16'(waiting && !tmo);
      err_q <= err_q || tmo;
    end
  assign err = err_q;
`else
  assign tmo = ACK_TIMEOUT < 1;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_retention_power_sequencer.sv
// tb_retention_power_sequencer: phase-table model plus directed checks of the retention power sequencer
module tb_retention_power_sequencer;
  localparam int S = 2;
  localparam int ACK_TO = 8;
`ifdef RET_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [7:0] TBL [12] = '{
    8'b00011100, 8'b10011101, 8'b00111101, 8'b00101101,
    8'b00100101, 8'b00100001, 8'b00100010, 8'b00100101,
    8'b00101101, 8'b00111101, 8'b01111101, 8'b00011101
  };
  localparam logic [8:0] RUN_OUTS = 9'b000111000;
  logic clk = 1'b0;
  logic rst, sleep_req, wake_req, pwr_ack;
  logic save, restore, iso_en, clk_en, dom_rst_n, pwr_en, sleeping, busy, err;
  logic [8:0] outs;
  logic wr;
  logic [31:0] wdata, dom_reg, shadow;
  int n_cmp = 0, n_bad = 0;
  int m_ph, m_left, m_wait, m_ph_n, m_left_n, m_wait_n, m_to;
  logic m_err, m_err_n, m_go;
  int n_a, n_b, t_a, t_b, t_c, t_d, t_e;
  logic ctx;
  retention_power_sequencer #(.SETTLE_CYC(S), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .sleep_req(sleep_req), .wake_req(wake_req), .pwr_ack(pwr_ack),
    .save(save), .restore(restore), .iso_en(iso_en), .clk_en(clk_en), .dom_rst_n(dom_rst_n),
    .pwr_en(pwr_en), .sleeping(sleeping), .busy(busy), .err(err)
  );
  assign outs = {save, restore, iso_en, clk_en, dom_rst_n, pwr_en, sleeping, busy, err};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (save) shadow <= dom_reg;
    if (wr) dom_reg <= wdata;
    else if (!pwr_en) dom_reg <= '0;
    else if (restore) dom_reg <= shadow;
  end
  always_comb begin
    m_go = 1'b0;
    m_to = (m_ph + 1) % 12;
    m_left_n = m_left;
    m_wait_n = m_wait;
    m_err_n = m_err;
    if (m_ph == 0) m_go = sleep_req;
    else if (m_ph == 6) m_go = wake_req;
    else if (m_ph == 1 || m_ph == 10) m_go = 1'b1;
    else if (m_ph == 5 || m_ph == 7) begin
      if (pwr_ack == (m_ph == 7)) m_go = 1'b1;
      else begin
        m_wait_n = m_wait + 1;
        if (TMO_EN && m_wait_n >= ACK_TO) begin
          m_err_n = 1'b1;
          if (m_ph == 5) begin
            m_go = 1'b1;
            m_to = 7;
          end
        end
      end
    end else begin
      m_left_n = m_left - 1;
      m_go = m_left_n == 0;
    end
    m_ph_n = m_go ? m_to : m_ph;
    if (m_go) begin
      m_left_n = S;
      m_wait_n = 0;
    end
  end
  always @(posedge clk)
    if (rst) begin
      m_ph <= 0;
      m_left <= 0;
      m_wait <= 0;
      m_err <= 1'b0;
    end else begin
      m_ph <= m_ph_n;
      m_left <= m_left_n;
      m_wait <= m_wait_n;
      m_err <= m_err_n;
    end
  always @(negedge clk) begin
    n_cmp++;
    if (outs !== {TBL[m_ph], m_err}) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t phase=%0d got=%b expected=%b", $time, m_ph, outs, {TBL[m_ph], m_err});
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1; sleep_req = 1'b0; wake_req = 1'b0; pwr_ack = 1'b1; wr = 1'b0; wdata = '0;
    cyc();
    cyc();
    chk("reset_outs", 32'(outs), 32'(RUN_OUTS));
    rst = 1'b0; wr = 1'b1; wdata = 32'hDEADBEEF;
    cyc();
    wr = 1'b0;
    sleep_req = 1'b1;
    cyc();
    sleep_req = 1'b0;
    n_a = 0; t_a = -1; t_b = -1; t_c = -1; t_d = -1; t_e = -1;
    for (int i = 0; i < 20; i++) begin
      if (save) n_a++;
      if (iso_en && t_a < 0) t_a = i;
      if (!clk_en && t_b < 0) t_b = i;
      if (!dom_rst_n && t_c < 0) t_c = i;
      if (!pwr_en && t_d < 0) begin
        t_d = i;
        pwr_ack = 1'b0;
      end
      if (sleeping) begin
        t_e = i;
        break;
      end
      cyc();
    end
    chk("save_cycles", n_a, 1);
    chk("iso_rise_at", t_a, 1);
    chk("clk_fall_at", t_b, 3);
    chk("rst_fall_at", t_c, 5);
    chk("pwr_fall_at", t_d, 7);
    chk("sleep_at", t_e, 8);
    chk("lost_in_sleep", dom_reg, 0);
    repeat (3) cyc();
    chk("sleep_hold", 32'(sleeping), 1);
    wake_req = 1'b1;
    cyc();
    wake_req = 1'b0;
    n_a = 0; t_a = -1; t_b = -1; ctx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) pwr_ack = 1'b1;
      if (restore) begin
        n_a++;
        t_a = i;
        ctx = dom_rst_n && clk_en && iso_en;
      end
      if (!busy && !sleeping) begin
        t_b = i;
        break;
      end
      cyc();
    end
    chk("restore_cycles", n_a, 1);
    chk("restore_at", t_a, 7);
    chk("restore_ctx", 32'(ctx), 1);
    chk("run_at", t_b, 10);
    chk("retained", dom_reg, 32'hDEADBEEF);
    sleep_req = 1'b1; wake_req = 1'b1;
    cyc();
    sleep_req = 1'b0;
    chk("both_req_save", 32'(save), 1);
    n_a = 0; t_a = -1;
    for (int i = 0; i < 20; i++) begin
      if (!pwr_en) pwr_ack = 1'b0;
      if (sleeping) n_a++;
      if (n_a > 0 && !sleeping) begin
        t_a = i;
        break;
      end
      cyc();
    end
    chk("sleep_cycles", n_a, 1);
    chk("pwr_on_at", t_a, 9);
    chk("pwr_on_en", 32'(pwr_en), 1);
    pwr_ack = 1'b1; wake_req = 1'b0; sleep_req = 1'b1;
    t_a = -1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        t_a = i;
        break;
      end
      cyc();
    end
    chk("run_after_pon", t_a, 8);
    cyc();
    sleep_req = 1'b0;
    chk("rerun_save", 32'(save), 1);
    t_a = -1;
    for (int i = 0; i < 20; i++) begin
      if (!clk_en) begin
        t_a = i;
        break;
      end
      cyc();
    end
    chk("clk_off_at", t_a, 3);
    rst = 1'b1;
    cyc();
    chk("rst_abort", 32'(outs), 32'(RUN_OUTS));
    rst = 1'b0;
    cyc();
`ifdef RET_SEQ_TIMEOUT_EN
    sleep_req = 1'b1;
    cyc();
    sleep_req = 1'b0;
    n_a = 0; t_a = -1;
    for (int i = 0; i < 40; i++) begin
      if (err) begin
        t_a = i;
        break;
      end
      if (!pwr_en) n_a++;
      cyc();
    end
    chk("pwr_off_cycles", n_a, ACK_TO);
    chk("err_at", t_a, 7 + ACK_TO);
    chk("abort_pwr_on", 32'(pwr_en), 1);
    n_b = 0; t_b = -1;
    for (int i = 0; i < 40; i++) begin
      if (restore) n_b++;
      if (!busy) begin
        t_b = i;
        break;
      end
      cyc();
    end
    chk("tmo_restore_once", n_b, 1);
    chk("tmo_run_reached", 32'(t_b > 0), 1);
    repeat (5) cyc();
    chk("err_sticky", 32'(err), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("err_cleared", 32'(err), 0);
`else
    sleep_req = 1'b1;
    cyc();
    sleep_req = 1'b0;
    repeat (30) cyc();
    chk("stuck_pwr_off", 32'({pwr_en, busy, err}), 32'(3'b010));
    pwr_ack = 1'b0;
    cyc();
    cyc();
    chk("late_ack_sleep", 32'(sleeping), 1);
    wake_req = 1'b1; pwr_ack = 1'b1;
    cyc();
    wake_req = 1'b0;
    t_a = -1;
    for (int i = 0; i < 20; i++) begin
      if (!busy && !sleeping) begin
        t_a = i;
        break;
      end
      cyc();
    end
    chk("late_run_at", t_a, 8);
`endif
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
